// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-bus and execute-handoff signals of the PC sequencer.
// master = PC sequencer side, slave = memory / execute side.
interface pc_fetch_ctrl_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_rsp_inst;
    logic            ifu_rsp_err;

    logic [XLEN-1:0] pc_IF;
    logic            inst_valid;
    logic [31:0]     inst;
    logic            inst_ready;
    logic            exu_jump;
    logic [XLEN-1:0] exu_target;
    logic            mret_req;
    logic [XLEN-1:0] mepc;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            halt_req;

    logic            halted;
    logic            fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err,
        output pc_IF, inst_valid, inst,
        input  inst_ready, exu_jump, exu_target, mret_req, mepc,
        input  trap_req, trap_vec, halt_req,
        output halted, fault, fault_pc
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst, ifu_rsp_err,
        input  pc_IF, inst_valid, inst,
        output inst_ready, exu_jump, exu_target, mret_req, mepc,
        output trap_req, trap_vec, halt_req,
        input  halted, fault, fault_pc
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: one fetch per instruction, hand-off to execute,
// next-PC selection on retirement, sticky halt on ebreak or fault.
module pc_fetch_ctrl #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input logic             clk,
    input logic             rst,
    pc_fetch_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] fault_pc;
    logic [31:0]     inst;
    logic            fault;
    logic            npc_misaligned;

    // Retirement source priority: trap > mret > jump/branch > sequential.
    always_comb begin
        npc = pc + XLEN'(4);
        if (bus.trap_req) begin
            npc = bus.trap_vec;
        end else if (bus.mret_req) begin
            npc = bus.mepc;
        end else if (bus.exu_jump) begin
            npc = bus.exu_target;
        end
        npc_misaligned = (npc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            inst     <= '0;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (bus.ifu_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.ifu_rsp_valid) begin
                        if (bus.ifu_rsp_err) begin
                            state    <= S_HALT;
                            fault    <= 1'b1;
                            fault_pc <= pc;
                        end else begin
                            inst  <= bus.ifu_rsp_inst;
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // Halting paths leave pc_IF at the retiring instruction.
                    if (bus.inst_ready) begin
                        if (bus.halt_req) begin
                            state <= S_HALT;
                        end else if (npc_misaligned) begin
                            state    <= S_HALT;
                            fault    <= 1'b1;
                            fault_pc <= npc;
                        end else begin
                            pc    <= npc;
                            state <= S_REQ;
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ifu_req_valid = (state == S_REQ);
    assign bus.ifu_req_addr  = pc;
    assign bus.pc_IF         = pc;
    assign bus.inst_valid    = (state == S_EXEC);
    assign bus.inst          = inst;
    assign bus.halted        = (state == S_HALT);
    assign bus.fault         = fault;
    assign bus.fault_pc      = fault_pc;
endmodule
